// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide: shift-add multiply, restoring divide.
// Latency: done pulses WIDTH+1 cycles after the accepting edge; result is registered.
// Backpressure: busy stalls the issuer; start while busy is dropped, flush aborts silently.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_operand1,
    input  logic [WIDTH-1:0] i_operand2,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_op;
    logic               r_sign1;
    logic               r_sign2;
    logic               r_div0;
    logic               r_ovf;
    logic [WIDTH-1:0]   r_mag1;     // multiplicand, or dividend shifting out MSB first
    logic [WIDTH-1:0]   r_mag2;     // multiplier shifting out LSB first, or divisor
    logic [2*WIDTH-1:0] r_acc;      // product, or {remainder, quotient}
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;

    logic               w_accept;
    logic               w_s1_signed;
    logic               w_s2_signed;
    logic               w_sign1;
    logic               w_sign2;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic               w_q_bit;
    logic [WIDTH-1:0]   w_div_diff;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fin_result;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [WIDTH-1:0]   w_result_nxt;

    // flush wins over start in IDLE, so a start coinciding with flush is dropped
    assign w_accept    = (r_state == S_IDLE) && i_start && !i_flush;
    assign w_s1_signed = (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV) || (i_op == OP_REM);
    assign w_s2_signed = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
    assign w_sign1     = w_s1_signed && i_operand1[WIDTH-1];
    assign w_sign2     = w_s2_signed && i_operand2[WIDTH-1];

    // Multiply step: add multiplicand into the high half, then shift the whole product right.
    assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{r_mag2[0]}} & r_mag1};
    // Restoring divide step on a WIDTH+1 bit partial remainder; when the subtract succeeds the
    // difference is below the divisor, so its low WIDTH bits hold it exactly.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_mag1[WIDTH-1]};
    assign w_q_bit     = (w_div_shift >= {1'b0, r_mag2});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_mag2;
    assign w_rem_nxt   = w_q_bit ? w_div_diff : w_div_shift[WIDTH-1:0];
    assign w_acc_nxt   = r_op[2] ? {w_rem_nxt, r_acc[WIDTH-2:0], w_q_bit}
                                 : {w_mul_sum, r_acc[WIDTH-1:1]};

    // Sign correction; signs are already zero for the unsigned variants.
    assign w_prod = (r_sign1 ^ r_sign2) ? -r_acc : r_acc;
    assign w_quo  = (r_sign1 ^ r_sign2) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_sign1 ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // Result selection and special-case overrides applied in FIN.
    // With a zero divisor the restoring loop shifts the whole dividend magnitude into the
    // remainder, so the sign-corrected remainder already equals operand1.
    always_comb begin
        w_fin_result = w_prod[WIDTH-1:0];
        case (r_op)
            OP_MUL:                        w_fin_result = w_prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_fin_result = w_prod[2*WIDTH-1:WIDTH];
            OP_DIV:  w_fin_result = r_div0 ? '1 : (r_ovf ? MIN_NEG : w_quo);
            OP_DIVU: w_fin_result = r_div0 ? '1 : w_quo;
            OP_REM:  w_fin_result = (r_ovf && !r_div0) ? '0 : w_rem;
            OP_REMU: w_fin_result = w_rem;
            default: w_fin_result = w_prod[WIDTH-1:0];
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_CALC;
            S_CALC: begin
                if (i_flush)
                    w_state_nxt = S_IDLE;
                else if (r_cnt == CNT_W'(WIDTH - 1))
                    w_state_nxt = S_FIN;
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        w_busy_nxt   = (w_state_nxt == S_CALC) || (w_state_nxt == S_FIN);
        w_done_nxt   = (r_state == S_FIN) && !i_flush;
        w_result_nxt = w_done_nxt ? w_fin_result : r_result;
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
        end
    end

    // Operand capture at the accepting edge, then one iteration per CALC cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op    <= '0;
            r_sign1 <= 1'b0;
            r_sign2 <= 1'b0;
            r_div0  <= 1'b0;
            r_ovf   <= 1'b0;
            r_mag1  <= '0;
            r_mag2  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_op    <= i_op;
            r_sign1 <= w_sign1;
            r_sign2 <= w_sign2;
            r_div0  <= (i_operand2 == '0);
            r_ovf   <= (i_operand1 == MIN_NEG) && (i_operand2 == '1);
            r_mag1  <= w_sign1 ? -i_operand1 : i_operand1;
            r_mag2  <= w_sign2 ? -i_operand2 : i_operand2;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_CALC) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_op[2])
                r_mag1 <= {r_mag1[WIDTH-2:0], 1'b0};
            else
                r_mag2 <= {1'b0, r_mag2[WIDTH-1:1]};
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at WIDTH=32 and WIDTH=8: directed cases, control boundaries, random sweep.
// Expected results are queued at launch and compared when done pulses.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_muldiv_unit;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
    localparam int LIMIT = 200;

    logic clk = 1'b0;
    logic rst_n;

    logic        start32, flush32, busy32, done32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, res32;

    logic        start8, flush8, busy8, done8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, res8;

    int checks = 0;
    int errors = 0;
    int done_cnt32 = 0;
    int done_cnt8 = 0;
    logic [31:0] last32 = '0;
    logic [7:0]  last8 = '0;
    logic [31:0] pop32;
    logic [7:0]  pop8;
    logic [31:0] exp32[$];
    logic [7:0]  exp8[$];

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) u_dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start32), .i_op(op32),
        .i_operand1(a32), .i_operand2(b32), .i_flush(flush32),
        .o_busy(busy32), .o_done(done32), .o_result(res32)
    );

    muldiv_unit #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_op(op8),
        .i_operand1(a8), .i_operand2(b8), .i_flush(flush8),
        .o_busy(busy8), .o_done(done8), .o_result(res8)
    );

    // Behavioural reference using 64-bit host arithmetic on w-bit operands.
    function automatic logic [31:0] model(input int w, input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, ua, ub, r;
        longint sa, sb, sp, smin;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = ua[w-1] ? longint'(ua) - (longint'(1) <<< w) : longint'(ua);
        sb   = ub[w-1] ? longint'(ub) - (longint'(1) <<< w) : longint'(ub);
        smin = -(longint'(1) <<< (w - 1));
        case (op)
            MUL:    r = (ua * ub) & mask;
            MULH:   begin sp = (sa * sb) >>> w; r = mask & sp; end
            MULHSU: begin sp = (sa * longint'(ub)) >>> w; r = mask & sp; end
            MULHU:  r = ((ua * ub) >> w) & mask;
            DIV: begin
                if (ub == 0) r = mask;
                else if (sa == smin && sb == -1) r = ua;
                else begin sp = sa / sb; r = mask & sp; end
            end
            DIVU:   r = (ub == 0) ? mask : ua / ub;
            REM: begin
                if (ub == 0) r = ua;
                else if (sa == smin && sb == -1) r = 64'd0;
                else begin sp = sa % sb; r = mask & sp; end
            end
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return r[31:0];
    endfunction

    // Scoreboard for the 32-bit instance.
    always @(negedge clk) begin
        if (rst_n && done32 === 1'b1) begin
            done_cnt32++;
            checks++;
            if (exp32.size() == 0) begin
                errors++;
                $display("FAIL sb32_unexpected_done: got result=%h, required no done", res32);
            end else begin
                pop32 = exp32.pop_front();
                last32 = pop32;
                if (res32 !== pop32) begin
                    errors++;
                    $display("FAIL sb32_result: got %h, required %h", res32, pop32);
                end
            end
        end
    end

    // Scoreboard for the 8-bit instance.
    always @(negedge clk) begin
        if (rst_n && done8 === 1'b1) begin
            done_cnt8++;
            checks++;
            if (exp8.size() == 0) begin
                errors++;
                $display("FAIL sb8_unexpected_done: got result=%h, required no done", res8);
            end else begin
                pop8 = exp8.pop_front();
                last8 = pop8;
                if (res8 !== pop8) begin
                    errors++;
                    $display("FAIL sb8_result: got %h, required %h", res8, pop8);
                end
            end
        end
    end

    // Drive a one-cycle start at the current falling edge, then scramble the operands.
    task automatic launch32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input bit push);
        start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        if (push) exp32.push_back(exp);
        @(negedge clk);
        start32 = 1'b0; op32 = 3'($urandom); a32 = $urandom; b32 = $urandom;
    endtask

    task automatic launch8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp, input bit push);
        start8 = 1'b1; op8 = op; a8 = a; b8 = b;
        if (push) exp8.push_back(exp);
        @(negedge clk);
        start8 = 1'b0; op8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    // Cycles from the falling edge after the start edge until done; LIMIT means timeout.
    task automatic wait_done32(output int n);
        n = 0;
        while (done32 !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    endtask

    task automatic wait_done8(output int n);
        n = 0;
        while (done8 !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    endtask

    task automatic test_reset();
        checks++; if (busy32 !== 1'b0)  begin errors++; $display("FAIL reset_busy32: got %b, required 0", busy32); end
        checks++; if (done32 !== 1'b0)  begin errors++; $display("FAIL reset_done32: got %b, required 0", done32); end
        checks++; if (res32 !== 32'd0)  begin errors++; $display("FAIL reset_result32: got %h, required 0", res32); end
        checks++; if (busy8 !== 1'b0)   begin errors++; $display("FAIL reset_busy8: got %b, required 0", busy8); end
        checks++; if (done8 !== 1'b0)   begin errors++; $display("FAIL reset_done8: got %b, required 0", done8); end
        checks++; if (res8 !== 8'd0)    begin errors++; $display("FAIL reset_result8: got %h, required 0", res8); end
    endtask

    task automatic test_mul();
        int n, bcnt;
        launch32(MUL, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b1);
        bcnt = (busy32 === 1'b1) ? 1 : 0;
        n = 0;
        while (done32 !== 1'b1 && n < LIMIT) begin
            @(negedge clk); n++;
            if (busy32 === 1'b1) bcnt++;
        end
        checks++; if (n != 33)    begin errors++; $display("FAIL mul_latency: got %0d, required 33", n); end
        checks++; if (bcnt != 33) begin errors++; $display("FAIL mul_busy_cycles: got %0d, required 33", bcnt); end
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL mul_busy_in_done: got %b, required 0", busy32); end
        @(negedge clk);
        checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL mul_done_pulse: got %b, required 0", done32); end
        checks++; if (res32 !== 32'hFFFF_FFD6) begin errors++; $display("FAIL mul_result_held: got %h, required ffffffd6", res32); end
    endtask

    task automatic test_mulh();
        logic [2:0]  ops[4];
        logic [31:0] av[4], bv[4], ev[4];
        int n;
        ops = '{MULH, MULHU, MULHSU, MULHU};
        av  = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        bv  = '{32'h8000_0000, 32'h8000_0000, 32'd2, 32'd2};
        ev  = '{32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'h0000_0001};
        for (int i = 0; i < 4; i++) begin
            launch32(ops[i], av[i], bv[i], ev[i], 1'b1);
            wait_done32(n);
            checks++; if (n != 33) begin errors++; $display("FAIL mulh_latency[%0d]: got %0d, required 33", i, n); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops[3];
        logic [31:0] ev[3];
        int n;
        ops = '{DIV, REM, DIVU};
        ev  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC};
        for (int i = 0; i < 3; i++) begin
            launch32(ops[i], 32'hFFFF_FFF9, 32'd2, ev[i], 1'b1);
            wait_done32(n);
            checks++; if (n != 33) begin errors++; $display("FAIL div_latency[%0d]: got %0d, required 33", i, n); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops[4];
        logic [31:0] av[4], bv[4], ev[4];
        int n;
        ops = '{DIV, REMU, DIV, REM};
        av  = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
        bv  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ev  = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            launch32(ops[i], av[i], bv[i], ev[i], 1'b1);
            wait_done32(n);
            checks++; if (n != 33) begin errors++; $display("FAIL special_latency[%0d]: got %0d, required 33", i, n); end
        end
    endtask

    task automatic test_restart();
        int d0;
        launch32(MUL, 32'd3, 32'd5, 32'd15, 1'b1);
        d0 = done_cnt32;
        repeat (5) @(negedge clk);
        start32 = 1'b1; op32 = DIVU; a32 = 32'd1000; b32 = 32'd7;
        @(negedge clk);
        start32 = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (done_cnt32 - d0 != 1) begin errors++; $display("FAIL restart_done_count: got %0d, required 1", done_cnt32 - d0); end
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL restart_busy: got %b, required 0", busy32); end
    endtask

    task automatic test_flush();
        int d0, n;
        // flush in CALC, then restart immediately
        launch32(MULHU, $urandom, $urandom, 32'd0, 1'b0);
        d0 = done_cnt32;
        repeat (9) @(negedge clk);
        flush32 = 1'b1;
        @(negedge clk);
        flush32 = 1'b0;
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL flush_calc_busy: got %b, required 0", busy32); end
        checks++; if (res32 !== last32) begin errors++; $display("FAIL flush_calc_result: got %h, required %h", res32, last32); end
        launch32(MUL, 32'd1000, 32'd3000, 32'd3000000, 1'b1);
        checks++; if (busy32 !== 1'b1) begin errors++; $display("FAIL flush_restart_busy: got %b, required 1", busy32); end
        wait_done32(n);
        checks++; if (n != 33) begin errors++; $display("FAIL flush_restart_latency: got %0d, required 33", n); end
        @(negedge clk);
        checks++; if (done_cnt32 - d0 != 1) begin errors++; $display("FAIL flush_calc_done_count: got %0d, required 1", done_cnt32 - d0); end
        // flush in FIN suppresses done
        launch32(DIV, 32'd100, 32'd7, 32'd0, 1'b0);
        d0 = done_cnt32;
        repeat (32) @(negedge clk);
        checks++; if (busy32 !== 1'b1) begin errors++; $display("FAIL flush_fin_busy_before: got %b, required 1", busy32); end
        flush32 = 1'b1;
        @(negedge clk);
        flush32 = 1'b0;
        checks++; if (done32 !== 1'b0 || busy32 !== 1'b0) begin errors++; $display("FAIL flush_fin_outputs: got done=%b busy=%b, required 0 0", done32, busy32); end
        repeat (5) @(negedge clk);
        checks++; if (done_cnt32 != d0) begin errors++; $display("FAIL flush_fin_done_count: got %0d, required 0", done_cnt32 - d0); end
        checks++; if (res32 !== last32) begin errors++; $display("FAIL flush_fin_result: got %h, required %h", res32, last32); end
        // flush together with start in IDLE drops the start
        d0 = done_cnt32;
        start32 = 1'b1; flush32 = 1'b1; op32 = MUL; a32 = 32'd9; b32 = 32'd9;
        @(negedge clk);
        start32 = 1'b0; flush32 = 1'b0;
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL flush_idle_busy: got %b, required 0", busy32); end
        repeat (40) @(negedge clk);
        checks++; if (done_cnt32 != d0) begin errors++; $display("FAIL flush_idle_done_count: got %0d, required 0", done_cnt32 - d0); end
    endtask

    task automatic test_width8();
        int n;
        logic [31:0] m;
        logic [7:0]  a, b;
        launch8(MULHU, 8'hF0, 8'h0F, 8'h0E, 1'b1);
        wait_done8(n);
        checks++; if (n != 9) begin errors++; $display("FAIL w8_latency: got %0d, required 9", n); end
        // back-to-back sweep: each start is issued in the previous done cycle
        for (int i = 0; i < 32; i++) begin
            a = 8'($urandom);
            b = (i % 5 == 0) ? 8'h00 : 8'($urandom);
            if (i == 12 || i == 14) begin a = 8'h80; b = 8'hFF; end
            m = model(8, 3'(i % 8), {24'd0, a}, {24'd0, b});
            launch8(3'(i % 8), a, b, m[7:0], 1'b1);
            wait_done8(n);
            checks++; if (n != 9) begin errors++; $display("FAIL w8_b2b_latency[%0d]: got %0d, required 9", i, n); end
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        launch32(DIVU, 32'hDEAD_BEEF, 32'd3, 32'd0, 1'b0);
        d0 = done_cnt32;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, required 0", busy32); end
        checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b, required 0", done32); end
        checks++; if (res32 !== 32'd0) begin errors++; $display("FAIL rstmid_result32: got %h, required 0", res32); end
        checks++; if (res8 !== 8'd0)   begin errors++; $display("FAIL rstmid_result8: got %h, required 0", res8); end
        @(negedge clk);
        rst_n = 1'b1;
        last32 = '0;
        repeat (40) @(negedge clk);
        checks++; if (done_cnt32 != d0) begin errors++; $display("FAIL rstmid_done_count: got %0d, required 0", done_cnt32 - d0); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] a, b, m;
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = (i % 5 == 0) ? 32'd0 : $urandom;
            if (i == 12 || i == 14) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (i == 9) b = 32'd1;
            m = model(32, 3'(i % 8), a, b);
            launch32(3'(i % 8), a, b, m, 1'b1);
            wait_done32(n);
            checks++; if (n != 33) begin errors++; $display("FAIL b2b32_latency[%0d]: got %0d, required 33", i, n); end
        end
    endtask

    // Watchdog so a stuck DUT still ends the run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start32 = 1'b0; flush32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        start8 = 1'b0;  flush8 = 1'b0;  op8 = '0;  a8 = '0;  b8 = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_restart();
        test_flush();
        test_width8();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++; if (exp32.size() != 0) begin errors++; $display("FAIL sb32_leftover: got %0d pending, required 0", exp32.size()); end
        checks++; if (exp8.size() != 0)  begin errors++; $display("FAIL sb8_leftover: got %0d pending, required 0", exp8.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
